// File: rtl/biquad8_coeff_loader.sv
// WB initiator: one single-beat write per {adr,coef,last} command, plus optional commit write after last; accept->stb 1 cycle.
// Backpressure: cmd_ready_o low while a write/retry/update is in flight; during FLUSH commands are accepted and dropped.
module biquad8_coeff_loader #(
    parameter bit AUTO_UPDATE = 1'b1,
    parameter int TIMEOUT     = 255,
    parameter int MAX_RETRY   = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [6:0]  cmd_adr_i,
    input  logic [17:0] cmd_dat_i,
    input  logic        cmd_last_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [6:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_GAP, S_UPD, S_DONE, S_FLUSH
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  MAX_R    = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [6:0]  adr_q, adr_d;
    logic [17:0] dat_q, dat_d;
    logic        last_q, last_d;
    logic        upd_q, upd_d;
    logic [3:0]  retry_q, retry_d;
    logic [15:0] timer_q, timer_d;
    logic        err_q, err_d;
    logic        rdy_q, rdy_d;
    logic        cyc_q, cyc_d;
    logic [6:0]  wb_adr_q, wb_adr_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic [3:0]  wb_sel_q, wb_sel_d;
    logic        abort;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        last_d  = last_q;
        upd_d   = upd_q;
        retry_d = retry_q;
        timer_d = timer_q;
        err_d   = err_q;
        abort   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && rdy_q) begin
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    last_d  = cmd_last_i;
                    upd_d   = 1'b0;
                    err_d   = 1'b0;
                    retry_d = 4'd0;
                    timer_d = 16'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE, S_UPD: begin
                if (wb_err_i) begin
                    abort = 1'b1;
                end else if (wb_ack_i) begin
                    if (state_q == S_UPD) begin
                        state_d = S_DONE;
                    end else if (last_q && AUTO_UPDATE) begin
                        // Commit write gets its own retry budget after a one-cycle bus gap.
                        upd_d   = 1'b1;
                        retry_d = 4'd0;
                        state_d = S_GAP;
                    end else if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (wb_rty_i) begin
                    if (retry_q < MAX_R) begin
                        retry_d = retry_q + 4'd1;
                        state_d = S_GAP;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    abort = 1'b1;
                end else begin
                    timer_d = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
                end

                if (abort) begin
                    err_d   = 1'b1;
                    state_d = (last_q || upd_q) ? S_IDLE : S_FLUSH;
                end
            end
            S_GAP: begin
                timer_d = 16'd0;
                state_d = upd_q ? S_UPD : S_WRITE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (cmd_valid_i && rdy_q && cmd_last_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs are registered from the next state so they are stable for the whole strobe.
    always_comb begin
        cyc_d    = (state_d == S_WRITE) || (state_d == S_UPD);
        rdy_d    = (state_d == S_IDLE) || (state_d == S_FLUSH);
        wb_sel_d = cyc_d ? 4'hF : 4'h0;
        wb_adr_d = 7'h00;
        wb_dat_d = 32'h0;
        if (state_d == S_WRITE) begin
            wb_adr_d = adr_d & 7'h7C;
            wb_dat_d = {14'd0, dat_d};
        end else if (state_d == S_UPD) begin
            wb_dat_d = 32'h1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            adr_q    <= 7'h00;
            dat_q    <= 18'h0;
            last_q   <= 1'b0;
            upd_q    <= 1'b0;
            retry_q  <= 4'd0;
            timer_q  <= 16'd0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
            cyc_q    <= 1'b0;
            wb_adr_q <= 7'h00;
            wb_dat_q <= 32'h0;
            wb_sel_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            last_q   <= last_d;
            upd_q    <= upd_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            rdy_q    <= rdy_d;
            cyc_q    <= cyc_d;
            wb_adr_q <= wb_adr_d;
            wb_dat_q <= wb_dat_d;
            wb_sel_q <= wb_sel_d;
        end
    end

    assign cmd_ready_o = rdy_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = cyc_q;
    assign wb_adr_o    = wb_adr_q;
    assign wb_dat_o    = wb_dat_q;
    assign wb_sel_o    = wb_sel_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;
endmodule
